seg_scan_decoder: RTL



---
 rtl/seg_scan_pkg.sv | 31 +++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/seg_scan_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the scanned 7-segment receive path: glyph codes, FSM states, digit count.
// Pure declarations; no latency or flow control.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment patterns as seen on the active-low bus, bit 6 = g .. bit 0 = a
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HELD
  } scan_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low segment pattern to hex value; legal=0 for anything not in the glyph set.
// Zero latency, no flow control.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] value
);

  always_comb begin
    legal = 1'b1;
    value = 4'h0;
    case (seg)
      GLYPH_0: value = 4'h0;
      GLYPH_1: value = 4'h1;
      GLYPH_2: value = 4'h2;
      GLYPH_3: value = 4'h3;
      GLYPH_4: value = 4'h4;
      GLYPH_5: value = 4'h5;
      GLYPH_6: value = 4'h6;
      GLYPH_7: value = 4'h7;
      GLYPH_8: value = 4'h8;
      GLYPH_9: value = 4'h9;
      GLYPH_A: value = 4'hA;
      GLYPH_B: value = 4'hB;
      GLYPH_C: value = 4'hC;
      GLYPH_D: value = 4'hD;
      GLYPH_E: value = 4'hE;
      GLYPH_F: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 8 scanned display digits into a 32-bit word; writes land SYNC_STAGES+STABLE_CYCLES
// cycles after a tuple appears on the pins. No backpressure: the display bus cannot be stalled.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [7:0]  an,
  output logic [31:0] hex_out,
  output logic [7:0]  dp_out,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err,
  output logic [2:0]  err_digit
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Synchroniser idles at all-ones so reset looks like a blank, unlit bus
  logic [15:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {an, dp, seg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [7:0] an_s;
  logic       dp_s;
  logic [6:0] seg_s;
  assign {an_s, dp_s, seg_s} = sync_q[SYNC_STAGES-1];

  logic [3:0] sel_zeros;
  logic [2:0] sel_idx;
  logic       sel_legal;

  always_comb begin
    sel_zeros = 4'd0;
    sel_idx   = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        sel_zeros = sel_zeros + 4'd1;
        sel_idx   = 3'(i);
      end
    end
    sel_legal = (sel_zeros == 4'd1);
  end

  logic       glyph_legal;
  logic [3:0] glyph_val;

  seg_glyph_decode u_glyph (
    .seg   (seg_s),
    .legal (glyph_legal),
    .value (glyph_val)
  );

  scan_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  lat_idx;
  logic [6:0]  lat_seg;
  logic        lat_dp;
  logic        load, wr, tuple_same;

  assign tuple_same = (sel_idx == lat_idx) && (seg_s == lat_seg) && (dp_s == lat_dp);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    wr        = 1'b0;
    case (state)
      IDLE: begin
        if (sel_legal) load = 1'b1;
      end
      COUNT, HELD: begin
        if (!sel_legal) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!tuple_same) begin
          load = 1'b1;
        end else if (state == COUNT) begin
          cnt_nxt = cnt + 8'd1;
          if (cnt_nxt == STABLE) begin
            state_nxt = HELD;
            wr        = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
    // A fresh tuple counts as its first stable sample
    if (load) begin
      cnt_nxt = 8'd1;
      if (STABLE == 8'd1) begin
        state_nxt = HELD;
        wr        = 1'b1;
      end else begin
        state_nxt = COUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      lat_idx <= 3'd0;
      lat_seg <= 7'd0;
      lat_dp  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        lat_idx <= sel_idx;
        lat_seg <= seg_s;
        lat_dp  <= dp_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out     <= 32'd0;
      dp_out      <= 8'd0;
      digit_valid <= 8'd0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_digit   <= 3'd0;
    end else begin
      frame_done <= (digit_valid == 8'hFF);
      err        <= wr && !glyph_legal;
      if (wr && !glyph_legal) err_digit <= sel_idx;
      if (wr && glyph_legal) begin
        hex_out[{sel_idx, 2'b00} +: 4] <= glyph_val;
        dp_out[sel_idx]                <= ~dp_s;
      end
      // Frame clear beats a write landing in the same cycle
      if (digit_valid == 8'hFF) digit_valid <= 8'd0;
      else if (wr && glyph_legal) digit_valid[sel_idx] <= 1'b1;
    end
  end

endmodule
